round_controller: RTL and testbench



---
 rtl/round_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_round_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// round_controller: game-phase sequencer for the two-tank arena.
// Drives the motion block's reset/freeze and tracks lives, rounds and the winner.
// All frame counting and hit sampling happen on the vsync-derived frame tick.
module round_controller #(
    parameter int unsigned LIVES            = 3,
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned HIT_PAUSE_FRAMES = 60,
    parameter logic [7:0]  START_KEY        = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       vs,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode2,
    input  logic       hit_tank1,
    input  logic       hit_tank2,
    output logic       game_reset,
    output logic       freeze,
    output logic [2:0] phase,
    output logic [2:0] p1_lives,
    output logic [2:0] p2_lives,
    output logic [1:0] winner,
    output logic [1:0] countdown_digit,
    output logic [7:0] round_num
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_HIT_PAUSE = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] CD_LOAD    = 8'(COUNTDOWN_FRAMES - 1);
    localparam logic [7:0] HP_LOAD    = 8'(HIT_PAUSE_FRAMES - 1);
    localparam logic [7:0] CD_TH3     = 8'((2 * COUNTDOWN_FRAMES) / 3);
    localparam logic [7:0] CD_TH2     = 8'(COUNTDOWN_FRAMES / 3);

    logic       vs_meta_r, vs_sync_r, vs_prev_r;
    logic       frame_tick_s;
    logic       start_lvl_r, start_lvl_d_r;
    logic       start_press_s;
    logic [2:0] state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic [2:0] p1_r, p1_s, p2_r, p2_s;
    logic [2:0] p1_dec_s, p2_dec_s;
    logic       any_hit_s;
    logic [1:0] winner_r, winner_s;
    logic [7:0] round_r, round_s;
    logic       game_reset_r, game_reset_s;
    logic       freeze_r, freeze_s;
    logic [2:0] phase_r, phase_s;
    logic [1:0] digit_r, digit_s;

    // Frame tick fires on the synchronised falling edge of vsync.
    assign frame_tick_s  = vs_prev_r & ~vs_sync_r;
    // A start key counts only on the cycle it first appears.
    assign start_press_s = start_lvl_r & ~start_lvl_d_r;
    // Life counts after a possible hit, floored at zero.
    assign any_hit_s = hit_tank1 | hit_tank2;
    assign p1_dec_s  = (hit_tank1 && (p1_r != 3'd0)) ? (p1_r - 3'd1) : p1_r;
    assign p2_dec_s  = (hit_tank2 && (p2_r != 3'd0)) ? (p2_r - 3'd1) : p2_r;

    // Synchronise vsync into Clk; flops idle at the vsync inactive level.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_meta_r <= 1'b1;
            vs_sync_r <= 1'b1;
            vs_prev_r <= 1'b1;
        end else begin
            vs_meta_r <= vs;
            vs_sync_r <= vs_meta_r;
            vs_prev_r <= vs_sync_r;
        end
    end

    // Register the start-key level; reset as "held" so a key held through reset must be re-pressed.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            start_lvl_r   <= 1'b1;
            start_lvl_d_r <= 1'b1;
        end else begin
            start_lvl_r   <= (keycode == START_KEY) | (keycode2 == START_KEY);
            start_lvl_d_r <= start_lvl_r;
        end
    end

    // Phase state and game datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 8'd0;
            p1_r     <= LIVES_INIT;
            p2_r     <= LIVES_INIT;
            winner_r <= 2'b00;
            round_r  <= 8'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            p1_r     <= p1_s;
            p2_r     <= p2_s;
            winner_r <= winner_s;
            round_r  <= round_s;
        end
    end

    // Next-state and datapath update for each phase.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        p1_s     = p1_r;
        p2_s     = p2_r;
        winner_s = winner_r;
        round_s  = round_r;
        case (state_r)
            ST_IDLE, ST_GAME_OVER: begin
                // Start wins over a coincident frame tick; the counter just loads.
                if (start_press_s) begin
                    state_s  = ST_COUNTDOWN;
                    cnt_s    = CD_LOAD;
                    p1_s     = LIVES_INIT;
                    p2_s     = LIVES_INIT;
                    winner_s = 2'b00;
                    round_s  = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_COUNTDOWN: begin
                if (frame_tick_s) begin
                    if (cnt_r != 8'd0) begin
                        cnt_s = cnt_r - 8'd1;
                    end else begin
                        state_s = ST_PLAY;
                        round_s = (round_r != 8'hFF) ? (round_r + 8'd1) : round_r;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_PLAY: begin
                // Leaving PLAY on the first sampled hit makes a held hit count once.
                if (frame_tick_s && any_hit_s) begin
                    p1_s = p1_dec_s;
                    p2_s = p2_dec_s;
                    if ((p1_dec_s == 3'd0) || (p2_dec_s == 3'd0)) begin
                        state_s  = ST_GAME_OVER;
                        winner_s = {(p1_dec_s == 3'd0), (p2_dec_s == 3'd0)};
                    end else begin
                        state_s = ST_HIT_PAUSE;
                        cnt_s   = HP_LOAD;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_HIT_PAUSE: begin
                if (frame_tick_s) begin
                    if (cnt_r != 8'd0) begin
                        cnt_s = cnt_r - 8'd1;
                    end else begin
                        state_s = ST_COUNTDOWN;
                        cnt_s   = CD_LOAD;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Decode the upcoming state so registered outputs track the state with no extra latency.
    always_comb begin
        game_reset_s = 1'b1;
        freeze_s     = 1'b1;
        phase_s      = state_s;
        digit_s      = 2'd0;
        case (state_s)
            ST_IDLE:      begin game_reset_s = 1'b1; freeze_s = 1'b1; end
            ST_COUNTDOWN: begin game_reset_s = 1'b1; freeze_s = 1'b1; end
            ST_PLAY:      begin game_reset_s = 1'b0; freeze_s = 1'b0; end
            ST_HIT_PAUSE: begin game_reset_s = 1'b0; freeze_s = 1'b1; end
            ST_GAME_OVER: begin game_reset_s = 1'b0; freeze_s = 1'b1; end
            default: begin
                game_reset_s = 1'b1;
                freeze_s     = 1'b1;
                phase_s      = ST_IDLE;
            end
        endcase
        if (state_s == ST_COUNTDOWN) begin
            if (cnt_s >= CD_TH3) begin
                digit_s = 2'd3;
            end else if (cnt_s >= CD_TH2) begin
                digit_s = 2'd2;
            end else begin
                digit_s = 2'd1;
            end
        end else begin
            digit_s = 2'd0;
        end
    end

    // Output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            game_reset_r <= 1'b1;
            freeze_r     <= 1'b1;
            phase_r      <= ST_IDLE;
            digit_r      <= 2'd0;
        end else begin
            game_reset_r <= game_reset_s;
            freeze_r     <= freeze_s;
            phase_r      <= phase_s;
            digit_r      <= digit_s;
        end
    end

    assign game_reset      = game_reset_r;
    assign freeze          = freeze_r;
    assign phase           = phase_r;
    assign countdown_digit = digit_r;
    assign p1_lives        = p1_r;
    assign p2_lives        = p2_r;
    assign winner          = winner_r;
    assign round_num       = round_r;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: directed game sequence with randomized hits, checked
// against a frame-level model of the game rules.
module tb_round_controller;

    localparam int CF = 180;
    localparam int HP = 60;
    localparam int NL = 3;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       vs = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic [7:0] keycode2 = 8'h00;
    logic       hit_tank1 = 1'b0;
    logic       hit_tank2 = 1'b0;
    logic       game_reset, freeze;
    logic [2:0] phase, p1_lives, p2_lives;
    logic [1:0] winner, countdown_digit;
    logic [7:0] round_num;

    round_controller dut (
        .Clk(Clk), .Reset_n(Reset_n), .vs(vs),
        .keycode(keycode), .keycode2(keycode2),
        .hit_tank1(hit_tank1), .hit_tank2(hit_tank2),
        .game_reset(game_reset), .freeze(freeze), .phase(phase),
        .p1_lives(p1_lives), .p2_lives(p2_lives), .winner(winner),
        .countdown_digit(countdown_digit), .round_num(round_num)
    );

    // 100 MHz bench clock.
    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;

    // Game model: phase, frames left in the timed phase, lives, winner, rounds.
    int m_phase, m_left, m_p1, m_p2, m_win, m_round;

    function automatic int exp_digit();
        if (m_phase != 1) return 0;
        return 3 - (CF - m_left) / (CF / 3);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_p1 = NL; m_p2 = NL; m_win = 0; m_round = 0;
    endtask

    task automatic model_press();
        if (m_phase == 0 || m_phase == 4) begin
            m_phase = 1; m_left = CF; m_p1 = NL; m_p2 = NL; m_win = 0; m_round = 0;
        end
    endtask

    task automatic model_tick(input bit h1, input bit h2);
        case (m_phase)
            1: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2;
                    m_round = (m_round < 255) ? m_round + 1 : 255;
                end
            end
            2: begin
                if (h1 || h2) begin
                    if (h1 && m_p1 > 0) m_p1--;
                    if (h2 && m_p2 > 0) m_p2--;
                    if (m_p1 == 0 || m_p2 == 0) begin
                        m_phase = 4;
                        m_win = (m_p1 == 0 ? 2 : 0) + (m_p2 == 0 ? 1 : 0);
                    end else begin
                        m_phase = 3;
                        m_left = HP;
                    end
                end
            end
            3: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 1;
                    m_left = CF;
                end
            end
            default: ;
        endcase
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input int exp);
        n_total++;
        assert (got === 32'(exp)) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        cmp({tag, " phase"}, 32'(phase), m_phase);
        cmp({tag, " game_reset"}, 32'(game_reset), (m_phase <= 1) ? 1 : 0);
        cmp({tag, " freeze"}, 32'(freeze), (m_phase != 2) ? 1 : 0);
        cmp({tag, " p1_lives"}, 32'(p1_lives), m_p1);
        cmp({tag, " p2_lives"}, 32'(p2_lives), m_p2);
        cmp({tag, " winner"}, 32'(winner), m_win);
        cmp({tag, " digit"}, 32'(countdown_digit), exp_digit());
        cmp({tag, " round_num"}, 32'(round_num), m_round);
    endtask

    // One vsync frame with the given hit levels held throughout.
    task automatic frame(input bit h1, input bit h2);
        hit_tank1 = h1;
        hit_tank2 = h2;
        @(negedge Clk) vs = 1'b0;
        repeat (3) @(negedge Clk);
        vs = 1'b1;
        repeat (3) @(negedge Clk);
        model_tick(h1, h2);
    endtask

    task automatic press(input bit use_p2);
        @(negedge Clk);
        if (use_p2) keycode2 = 8'h28; else keycode = 8'h28;
        repeat (3) @(negedge Clk);
        model_press();
    endtask

    task automatic release_keys();
        @(negedge Clk);
        keycode = 8'h00;
        keycode2 = 8'h00;
        repeat (2) @(negedge Clk);
    endtask

    // Start press lands on the same cycle as the frame tick.
    task automatic press_on_tick();
        @(negedge Clk) vs = 1'b0;
        @(negedge Clk) keycode = 8'h28;
        repeat (2) @(negedge Clk);
        vs = 1'b1;
        repeat (3) @(negedge Clk);
        model_press();
    endtask

    task automatic run_until(input int target, input int limit, input int mode, input string tag);
        for (int i = 0; i < limit && m_phase != target; i++) begin
            case (mode)
                1: frame(1'b1, 1'b1);
                2: frame(1'b1, 1'b0);
                3: frame($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
                default: frame(1'b0, 1'b0);
            endcase
            check_all(tag);
        end
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #900000;
        $display("FAIL timeout: sequence did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge Clk);
        check_all("reset");
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        check_all("after_release");

        // Hits in IDLE are ignored.
        for (int i = 0; i < 3; i++) begin
            frame($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            check_all("idle_hits");
        end

        // Key held for 10 frames starts exactly one countdown.
        press(1'b0);
        check_all("start_p1");
        for (int i = 0; i < 10; i++) begin
            frame(1'b0, 1'b0);
            check_all("key_held");
        end
        release_keys();
        run_until(2, 400, 0, "countdown1");
        check_all("play1");

        // Single hit on tank 2, pause, then next round.
        frame(1'b0, 1'b1);
        check_all("hit_p2");
        run_until(2, 400, 0, "pause_cd");
        check_all("play2");

        // Random hits until the game ends.
        run_until(4, 3000, 3, "random_play");
        for (int i = 0; i < 3; i++) begin
            frame($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            check_all("gameover_hits");
        end

        // Player-2 restart; both hits held continuously until a draw.
        press(1'b1);
        check_all("start_p2");
        release_keys();
        run_until(4, 2000, 1, "both_held");
        check_all("draw");

        // Restart coinciding with a frame tick; then tank 1 hit until it loses.
        press_on_tick();
        check_all("start_on_tick");
        release_keys();
        run_until(4, 2000, 2, "p1_held");
        check_all("p2_wins");

        // New game, one hit, then asynchronous reset inside HIT_PAUSE.
        press(1'b0);
        release_keys();
        run_until(2, 400, 0, "cd4");
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        check_all("in_pause");
        @(negedge Clk) keycode = 8'h28;
        repeat (3) @(negedge Clk);
        check_all("start_in_pause");
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1 model_reset();
        check_all("async_reset");
        repeat (2) @(negedge Clk);
        #2 Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        check_all("post_reset");
        for (int i = 0; i < 2; i++) begin
            frame(1'b0, 1'b0);
            check_all("held_key_ignored");
        end
        release_keys();
        press(1'b0);
        check_all("repress");
        for (int i = 0; i < 3; i++) begin
            frame(1'b0, 1'b0);
            check_all("cd_after_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
